// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension divider path.
//   XLEN          : datapath width
//   state_t       : divider sequencer states
//   OPDIV_*       : bit positions inside the 2-bit op_div code
//   cond_neg()    : two's-complement magnitude of a value when its sign applies
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int OPDIV_SIGNED = 0;
  localparam int OPDIV_REM    = 1;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] val, input logic neg);
    return neg ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step.
//   rem          in  XLEN  partial remainder before the step
//   dividend_msb in  1     dividend bit shifted into the remainder
//   divisor      in  XLEN  divisor magnitude
//   rem_next     out XLEN  partial remainder after the step
//   qbit         out 1     resolved quotient bit
module muldiv_div_step
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic            dividend_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            qbit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  assign shifted = {rem, dividend_msb};
  assign trial   = shifted - {1'b0, divisor};

  // rem < divisor on entry, so the 33-bit trial's top bit is its sign.
  // A zero divisor never sets it either (rem[31] stays clear until the
  // final shift), which yields the all-ones quotient naturally.
  assign qbit     = ~trial[XLEN];
  assign rem_next = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/muldiv_div_seq.sv
// Iterative radix-2^k restoring divider producing magnitude quotient and
// remainder; sign fix-up is left to the downstream output-correction stage.
// Optional macro MULDIV_DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle.
// Ports:
//   clk_i, reset_i (async, active low)
//   start_i, flush_i, dividend_i, divisor_i, op_div_i   request side
//   busy_o, done_o                                      handshake
//   quot_o, rem_o, dividend_neg_o, divisor_neg_o,
//   div_by_zero_o, op_div_o                             result, held until next start
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | BITS_PER_CYCLE restoring steps per cycle, counter counting down
// DONE  | one-cycle done_o pulse, results on the outputs
module muldiv_div_seq
  import muldiv_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [1:0]      op_div_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o,
  output logic            dividend_neg_o,
  output logic            divisor_neg_o,
  output logic            div_by_zero_o,
  output logic [1:0]      op_div_o
);

  localparam int N = XLEN / BITS_PER_CYCLE;
  localparam logic [4:0] CNT_INIT = 5'(N - 1);

`ifdef MULDIV_DIV_ZERO_FAST_EN
  localparam bit FAST_ZERO = 1'b1;
`else
  localparam bit FAST_ZERO = 1'b0;
`endif

  state_t state, state_nxt;

  logic [4:0]      cnt_q;
  logic [XLEN-1:0] rem_q, dvd_q, dsr_q;
  logic            dvd_neg_q, dsr_neg_q, zero_q;
  logic [1:0]      op_q;

  logic            accept, fast_zero, last;
  logic            in_dvd_neg, in_dsr_neg, in_zero;
  logic [XLEN-1:0] in_dvd_mag, in_dsr_mag;

  logic [XLEN-1:0]           rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] qbits;
  logic [XLEN-1:0]           dvd_next;

  assign accept     = (state == IDLE) && start_i && !flush_i;
  assign in_dvd_neg = op_div_i[OPDIV_SIGNED] && dividend_i[XLEN-1];
  assign in_dsr_neg = op_div_i[OPDIV_SIGNED] && divisor_i[XLEN-1];
  assign in_dvd_mag = cond_neg(dividend_i, in_dvd_neg);
  assign in_dsr_mag = cond_neg(divisor_i, in_dsr_neg);
  assign in_zero    = (divisor_i == '0);
  assign fast_zero  = FAST_ZERO && accept && in_zero;
  assign last       = (state == RUN) && !flush_i && (cnt_q == '0);

  // Step i consumes dividend bit 31-i; its quotient bit is the (i)th most
  // significant of the bits shifted in this cycle.
  assign rem_chain[0] = rem_q;
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    muldiv_div_step u_step (
      .rem          (rem_chain[i]),
      .dividend_msb (dvd_q[XLEN-1-i]),
      .divisor      (dsr_q),
      .rem_next     (rem_chain[i+1]),
      .qbit         (qbits[BITS_PER_CYCLE-1-i])
    );
  end
  assign dvd_next = {dvd_q[XLEN-1-BITS_PER_CYCLE:0], qbits};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: begin
        busy_o = accept;
        if (accept) state_nxt = fast_zero ? DONE : RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (flush_i)             state_nxt = IDLE;
        else if (cnt_q == '0)    state_nxt = DONE;
      end
      DONE: begin
        done_o    = !flush_i;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: operands and partial results during RUN.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      dvd_neg_q <= 1'b0;
      dsr_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      op_q      <= '0;
    end else if (accept) begin
      cnt_q     <= CNT_INIT;
      rem_q     <= '0;
      dvd_q     <= in_dvd_mag;
      dsr_q     <= in_dsr_mag;
      dvd_neg_q <= in_dvd_neg;
      dsr_neg_q <= in_dsr_neg;
      zero_q    <= in_zero;
      op_q      <= op_div_i;
    end else if (state == RUN && !flush_i) begin
      cnt_q <= cnt_q - 5'd1;
      rem_q <= rem_chain[BITS_PER_CYCLE];
      dvd_q <= dvd_next;
    end
  end

  // Result registers only change on completion, so a flushed operation
  // leaves the previous result visible.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      quot_o         <= '0;
      rem_o          <= '0;
      dividend_neg_o <= 1'b0;
      divisor_neg_o  <= 1'b0;
      div_by_zero_o  <= 1'b0;
      op_div_o       <= '0;
    end else if (fast_zero) begin
      quot_o         <= '1;
      rem_o          <= in_dvd_mag;
      dividend_neg_o <= in_dvd_neg;
      divisor_neg_o  <= in_dsr_neg;
      div_by_zero_o  <= 1'b1;
      op_div_o       <= op_div_i;
    end else if (last) begin
      quot_o         <= dvd_next;
      rem_o          <= rem_chain[BITS_PER_CYCLE];
      dividend_neg_o <= dvd_neg_q;
      divisor_neg_o  <= dsr_neg_q;
      div_by_zero_o  <= zero_q;
      op_div_o       <= op_q;
    end
  end

endmodule

// File: tb/tb_muldiv_div_seq.sv
// Self-checking bench for muldiv_div_seq: one instance per BITS_PER_CYCLE
// value, both driven with the same stimulus and checked against an
// arithmetic reference model. Honours MULDIV_DIV_ZERO_FAST_EN.
module tb_muldiv_div_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [1:0]  op = '0;

  logic        busy1, done1, dn1, sn1, z1;
  logic [31:0] q1, r1;
  logic [1:0]  op1;
  logic        busy2, done2, dn2, sn2, z2;
  logic [31:0] q2, r2;
  logic [1:0]  op2;

`ifdef MULDIV_DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  always #5 clk = ~clk;

  muldiv_div_seq #(.BITS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .reset_i(reset_n), .start_i(start), .flush_i(flush),
    .dividend_i(dividend), .divisor_i(divisor), .op_div_i(op),
    .busy_o(busy1), .done_o(done1), .quot_o(q1), .rem_o(r1),
    .dividend_neg_o(dn1), .divisor_neg_o(sn1), .div_by_zero_o(z1), .op_div_o(op1)
  );

  muldiv_div_seq #(.BITS_PER_CYCLE(2)) dut2 (
    .clk_i(clk), .reset_i(reset_n), .start_i(start), .flush_i(flush),
    .dividend_i(dividend), .divisor_i(divisor), .op_div_i(op),
    .busy_o(busy2), .done_o(done2), .quot_o(q2), .rem_o(r2),
    .dividend_neg_o(dn2), .divisor_neg_o(sn2), .div_by_zero_o(z2), .op_div_o(op2)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Expected visible results: {dividend_neg, divisor_neg, div_by_zero, op}
  logic [31:0] eq = '0;
  logic [31:0] er = '0;
  logic [4:0]  ef = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                       output logic [31:0] q, output logic [31:0] r, output logic [4:0] f);
    logic        sg;
    logic [31:0] ma, mb;
    sg = o[0];
    ma = (sg && a[31]) ? (32'd0 - a) : a;
    mb = (sg && b[31]) ? (32'd0 - b) : b;
    if (mb == 0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    f = {sg && a[31], sg && b[31], b == 32'd0, o};
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_quot1"}, q1, eq);
    chk({tag, "_rem1"}, r1, er);
    chk({tag, "_flags1"}, 32'({dn1, sn1, z1, op1}), 32'(ef));
    chk({tag, "_quot2"}, q2, eq);
    chk({tag, "_rem2"}, r2, er);
    chk({tag, "_flags2"}, 32'({dn2, sn2, z2, op2}), 32'(ef));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_zero1"}, 32'({q1, r1, dn1, sn1, z1, op1, busy1, done1} != '0), 32'd0);
    chk({tag, "_zero2"}, 32'({q2, r2, dn2, sn2, z2, op2, busy2, done2} != '0), 32'd0);
  endtask

  // Called at a falling edge. restart_at/flush_at/reset_at give the cycle
  // (1 = first cycle after the start edge) of a disturbing event, 0 = none.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] o, input int restart_at, input int flush_at,
                        input int reset_at);
    logic [31:0] nq, nr;
    logic [4:0]  nf;
    int lat1, lat2, p1, p2, exp1, exp2;
    bit aborted;
    model(a, b, o, nq, nr, nf);
    lat1 = 0; lat2 = 0; p1 = 0; p2 = 0; aborted = 1'b0;
    dividend = a; divisor = b; op = o; start = 1'b1;
    #1;
    chk({tag, "_busy1_accept"}, 32'(busy1), 32'd1);
    chk({tag, "_busy2_accept"}, 32'(busy2), 32'd1);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done1) begin p1++; if (lat1 == 0) lat1 = c; end
      if (done2) begin p2++; if (lat2 == 0) lat2 = c; end
      if (c == restart_at) begin
        dividend = $urandom; divisor = $urandom | 32'd1; op = 2'($urandom); start = 1'b1;
      end
      if (restart_at != 0 && c == restart_at + 1) start = 1'b0;
      if (c == flush_at) begin flush = 1'b1; aborted = 1'b1; end
      if (flush_at != 0 && c == flush_at + 1) flush = 1'b0;
      if (c == reset_at) begin
        reset_n = 1'b0;
        aborted = 1'b1;
        #1;
        check_zero({tag, "_async_reset"});
        eq = '0; er = '0; ef = '0;
      end
      if (reset_at != 0 && c == reset_at + 1) reset_n = 1'b1;
      @(negedge clk);
    end
    if (!aborted) begin
      eq = nq; er = nr; ef = nf;
    end
    exp1 = aborted ? 0 : ((FAST && b == 0) ? 1 : 33);
    exp2 = aborted ? 0 : ((FAST && b == 0) ? 1 : 17);
    chk({tag, "_latency1"}, 32'(lat1), 32'(exp1));
    chk({tag, "_latency2"}, 32'(lat2), 32'(exp2));
    chk({tag, "_pulses1"}, 32'(p1), aborted ? 32'd0 : 32'd1);
    chk({tag, "_pulses2"}, 32'(p2), aborted ? 32'd0 : 32'd1);
    chk({tag, "_idle_busy"}, 32'({busy1, busy2}), 32'd0);
    check_outputs(tag);
  endtask

  initial begin
    int d1, d2;
    logic [31:0] ra, rb;
    int sel;

    #1 reset_n = 1'b0;
    #2;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    run_op("u100_7",     32'd100,          32'd7,          2'b00, 0, 0, 0);
    run_op("s_m100_7",   32'hFFFF_FF9C,    32'd7,          2'b01, 0, 0, 0);
    run_op("div0",       32'd5,            32'd0,          2'b10, 0, 0, 0);
    run_op("s_ovf",      32'h8000_0000,    32'hFFFF_FFFF,  2'b01, 0, 0, 0);
    run_op("u_max_16",   32'hFFFF_FFFF,    32'h10,         2'b00, 0, 0, 0);
    run_op("small_big",  32'd7,            32'd9,          2'b11, 0, 0, 0);
    run_op("s_neg_neg",  32'hFFFF_FFF9,    32'hFFFF_FFFE,  2'b11, 0, 0, 0);
    run_op("restart",    32'd1000,         32'd3,          2'b11, 5, 0, 0);
    run_op("flush",      32'd12345,        32'd17,         2'b00, 0, 10, 0);
    run_op("after_fl",   32'hDEAD_BEEF,    32'd1,          2'b00, 0, 0, 0);
    run_op("reset_run",  32'd50,           32'd6,          2'b00, 0, 0, 10);
    run_op("after_rst",  32'd99,           32'd10,         2'b10, 0, 0, 0);

    // start together with flush in IDLE is dropped
    dividend = 32'd77; divisor = 32'd5; op = 2'b00; start = 1'b1; flush = 1'b1;
    #1;
    chk("start_flush_busy", 32'({busy1, busy2}), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    d1 = 0; d2 = 0;
    for (int c = 0; c < 40; c++) begin
      if (done1) d1++;
      if (done2) d2++;
      @(negedge clk);
    end
    chk("start_flush_done1", 32'(d1), 32'd0);
    chk("start_flush_done2", 32'(d2), 32'd0);
    check_outputs("start_flush");

    for (int i = 0; i < 24; i++) begin
      sel = int'($urandom_range(0, 9));
      ra = (sel == 3) ? 32'($urandom_range(0, 50)) : 32'($urandom);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        4:       rb = 32'($urandom) >> $urandom_range(0, 31);
        default: rb = 32'($urandom);
      endcase
      run_op($sformatf("rand%0d", i), ra, rb, 2'($urandom_range(0, 3)), 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
